ahb_resp_mux: RTL and testbench
===============================

Name: ahb_resp_mux

Overview:
- Return-path counterpart of the AHB address decoder. It sits between the slaves and the single master.
- It registers the decoder's one-hot slave select into the data phase, muxes HRDATA/HREADYOUT/HRESP from the selected slave back to the master, and broadcasts HREADY.
- It contains the built-in default slave for unmapped addresses (h_sel_x == 0), which returns the two-cycle AHB ERROR response.
- It keeps a saturating count of unmapped-access errors.

Parameters:
- DATA_WIDTH, 32, read data bus width.
- NUM_SLV, 5, number of slaves; matches the decoder's 5-bit one-hot select.
- CNT_WIDTH, 8, width of the error counter.

Ports:
- h_clk  in  1  system clock; all state updates on the rising edge.
- h_rst  in  1  reset; asynchronous, active-high.
- h_sel_x  in  NUM_SLV  one-hot address-phase select from the decoder; all-zero means unmapped.
- h_trans  in  2  master HTRANS: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- h_rdata_x  in  NUM_SLV*DATA_WIDTH  slave read data, packed; slave i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- h_readyout_x  in  NUM_SLV  slave HREADYOUT, bit i from slave i.
- h_resp_x  in  NUM_SLV  slave HRESP (AHB-Lite, 1 = ERROR), bit i from slave i.
- h_rdata  out  DATA_WIDTH  read data to the master.
- h_ready  out  1  HREADY to the master and broadcast to all slaves.
- h_resp  out  1  HRESP to the master.
- h_err_cnt  out  CNT_WIDTH  saturating count of completed default-slave ERROR responses.

Behaviour:
- Reset (async, h_rst=1): dsel <= 0, FSM <= D_IDLE, h_err_cnt <= 0. Outputs take effect immediately, without waiting for a clock edge: h_ready=1, h_resp=0, h_rdata=0.
- Reset mid-transfer behaves identically: the transfer is abandoned and no ERROR is completed or counted.
- Data-phase select register dsel[NUM_SLV-1:0]:
  - Loaded with h_sel_x on a rising edge where h_ready==1.
  - Holds its value while h_ready==0, so the address phase is extended along with the data phase.
- Address-phase capture flag: unmapped_req = (h_sel_x==0) & h_trans[1]. It is sampled only when h_ready==1.
- Output mux (combinational from dsel and the FSM):
  - dsel bit i set: h_rdata = slave i data, h_ready = h_readyout_x[i], h_resp = h_resp_x[i].
  - More than one dsel bit set: the lowest index wins. This is defined behaviour, not an error.
  - dsel==0: default slave drives h_rdata=0; h_ready and h_resp come from the FSM.
- Default slave FSM:
  - D_IDLE: h_ready=1, h_resp=0. Goes to D_ERR1 when h_ready & unmapped_req; otherwise stays in D_IDLE.
  - D_ERR1: h_ready=0, h_resp=1. Always goes to D_ERR2 on the next edge.
  - D_ERR2: h_ready=1, h_resp=1. h_err_cnt increments on exit unless it is at all-ones. Next state is D_ERR1 if unmapped_req, otherwise D_IDLE. Back-to-back unmapped transfers are therefore ERR1, ERR2, ERR1, ERR2, ...
- Unmapped IDLE or BUSY transfers (h_sel_x==0, h_trans[1]==0) get a zero-wait OKAY: FSM stays in D_IDLE, h_rdata=0.
- Mapped transfers leave the FSM in D_IDLE. The FSM only advances in the data phase of an unmapped NONSEQ/SEQ.
- Latency:
  - Zero combinational latency from slave response inputs to master outputs.
  - Exactly one cycle from address phase to data-phase select.
  - Default-slave ERROR takes exactly 2 data-phase cycles.
- Slave ERROR pass-through: the mux forwards whatever the slave drives, with no checking. h_err_cnt counts only default-slave errors.
- h_err_cnt saturates at 2^CNT_WIDTH-1 and does not wrap. It is cleared only by h_rst.

Test Plan:
1. Reset: assert h_rst mid-D_ERR1 with no clock edge → h_ready=1, h_resp=0, h_rdata=0, h_err_cnt=0 immediately.
2. Mapped read: h_sel_x=00100, h_trans=10; slave 2 drives 0xDEADBEEF, readyout=1, resp=0 → next cycle h_rdata=0xDEADBEEF, h_ready=1, h_resp=0.
3. Wait states: dsel=00010, slave 1 holds readyout=0 for 3 cycles while h_sel_x changes to 01000 → h_ready=0 for 3 cycles, dsel stays 00010, h_rdata follows slave 1, then switches to slave 3 after the cycle where h_ready=1.
4. Unmapped NONSEQ: h_sel_x=0, h_trans=10 → cycle+1 h_ready=0/h_resp=1, cycle+2 h_ready=1/h_resp=1, cycle+3 OKAY; h_err_cnt=1.
5. Back-to-back unmapped SEQ ×3, then IDLE → pattern ERR1,ERR2 repeated 3 times then D_IDLE; h_err_cnt=3. Unmapped IDLE alone → zero-wait OKAY, no count.
6. Saturation with CNT_WIDTH=2: 5 unmapped NONSEQs → h_err_cnt=3 and holds at 3. Multi-hot dsel=10100 → slave 2 outputs selected.

Source files
------------

// File: rtl/ahb_resp_mux.sv
// AHB-Lite return-path mux: registers the decoder select into the data phase,
// steers slave responses to the master and hosts the default (ERROR) slave.
module ahb_resp_mux #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLV    = 5,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                          h_clk,
  input  logic                          h_rst,
  input  logic [NUM_SLV-1:0]            h_sel_x,
  input  logic [1:0]                    h_trans,
  input  logic [NUM_SLV*DATA_WIDTH-1:0] h_rdata_x,
  input  logic [NUM_SLV-1:0]            h_readyout_x,
  input  logic [NUM_SLV-1:0]            h_resp_x,
  output logic [DATA_WIDTH-1:0]         h_rdata,
  output logic                          h_ready,
  output logic                          h_resp,
  output logic [CNT_WIDTH-1:0]          h_err_cnt
);

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_ERR1 = 2'd1,
    D_ERR2 = 2'd2
  } dstate_e;

  dstate_e                state_q, state_d;
  logic [NUM_SLV-1:0]     dsel_q, dsel_d;
  logic [CNT_WIDTH-1:0]   err_cnt_q, err_cnt_d;

  logic                   unmapped_req_s;
  logic [NUM_SLV-1:0]     dsel_low_s;
  logic                   dflt_ready_s;
  logic                   dflt_resp_s;
  logic [DATA_WIDTH-1:0]  slv_rdata_s;
  logic                   slv_ready_s;
  logic                   slv_resp_s;

  // Only NONSEQ/SEQ to an unmapped address earns an ERROR; IDLE/BUSY get OKAY.
  assign unmapped_req_s = (h_sel_x == {NUM_SLV{1'b0}}) &&
                          ((h_trans == 2'b10) || (h_trans == 2'b11));

  // Isolating the lowest set bit makes a multi-hot select resolve to the lowest index.
  assign dsel_low_s = dsel_q & (~dsel_q + NUM_SLV'(1));

  always_comb begin
    dflt_ready_s = 1'b1;
    dflt_resp_s  = 1'b0;
    case (state_q)
      D_IDLE: begin
        dflt_ready_s = 1'b1;
        dflt_resp_s  = 1'b0;
      end
      D_ERR1: begin
        dflt_ready_s = 1'b0;
        dflt_resp_s  = 1'b1;
      end
      D_ERR2: begin
        dflt_ready_s = 1'b1;
        dflt_resp_s  = 1'b1;
      end
      default: begin
        dflt_ready_s = 1'b1;
        dflt_resp_s  = 1'b0;
      end
    endcase
  end

  always_comb begin
    slv_rdata_s = {DATA_WIDTH{1'b0}};
    slv_ready_s = 1'b0;
    slv_resp_s  = 1'b0;
    for (int i = 0; i < NUM_SLV; i++) begin
      slv_rdata_s = slv_rdata_s |
                    ({DATA_WIDTH{dsel_low_s[i]}} & h_rdata_x[i*DATA_WIDTH +: DATA_WIDTH]);
      slv_ready_s = slv_ready_s | (dsel_low_s[i] & h_readyout_x[i]);
      slv_resp_s  = slv_resp_s  | (dsel_low_s[i] & h_resp_x[i]);
    end
  end

  always_comb begin
    h_rdata = slv_rdata_s;
    h_ready = slv_ready_s;
    h_resp  = slv_resp_s;
    if (dsel_q == {NUM_SLV{1'b0}}) begin
      h_rdata = {DATA_WIDTH{1'b0}};
      h_ready = dflt_ready_s;
      h_resp  = dflt_resp_s;
    end else begin
      h_rdata = slv_rdata_s;
      h_ready = slv_ready_s;
      h_resp  = slv_resp_s;
    end
  end

  assign h_err_cnt = err_cnt_q;

  always_comb begin
    state_d   = state_q;
    err_cnt_d = err_cnt_q;
    if (h_ready) begin
      dsel_d = h_sel_x;
    end else begin
      dsel_d = dsel_q;
    end
    case (state_q)
      D_IDLE: begin
        if (h_ready && unmapped_req_s) begin
          state_d = D_ERR1;
        end else begin
          state_d = D_IDLE;
        end
      end
      D_ERR1: begin
        state_d = D_ERR2;
      end
      D_ERR2: begin
        // Count is taken on leaving ERR2 so an abandoned (reset) ERROR is never counted.
        if (err_cnt_q != {CNT_WIDTH{1'b1}}) begin
          err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
        end else begin
          err_cnt_d = err_cnt_q;
        end
        if (unmapped_req_s) begin
          state_d = D_ERR1;
        end else begin
          state_d = D_IDLE;
        end
      end
      default: begin
        state_d = D_IDLE;
      end
    endcase
  end

  always_ff @(posedge h_clk or posedge h_rst) begin
    if (h_rst) begin
      state_q   <= D_IDLE;
      dsel_q    <= {NUM_SLV{1'b0}};
      err_cnt_q <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q   <= state_d;
      dsel_q    <= dsel_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Scoreboard bench for ahb_resp_mux: a reference model pushes expected outputs,
// the sampler pops and compares; a second instance with a 2-bit counter covers saturation.
module tb_ahb_resp_mux;

  localparam int DW = 32;
  localparam int NS = 5;

  logic            h_clk = 1'b0;
  logic            h_rst;
  logic [NS-1:0]   h_sel_x;
  logic [1:0]      h_trans;
  logic [NS*DW-1:0] h_rdata_x;
  logic [NS-1:0]   h_readyout_x;
  logic [NS-1:0]   h_resp_x;
  logic [DW-1:0]   h_rdata, rdata_b;
  logic            h_ready, ready_b;
  logic            h_resp, resp_b;
  logic [7:0]      h_err_cnt;
  logic [1:0]      cnt_b;

  always #5 h_clk = ~h_clk;

  ahb_resp_mux u_dut (
    .h_clk(h_clk), .h_rst(h_rst), .h_sel_x(h_sel_x), .h_trans(h_trans),
    .h_rdata_x(h_rdata_x), .h_readyout_x(h_readyout_x), .h_resp_x(h_resp_x),
    .h_rdata(h_rdata), .h_ready(h_ready), .h_resp(h_resp), .h_err_cnt(h_err_cnt)
  );

  ahb_resp_mux #(.CNT_WIDTH(2)) u_dut_sat (
    .h_clk(h_clk), .h_rst(h_rst), .h_sel_x(h_sel_x), .h_trans(h_trans),
    .h_rdata_x(h_rdata_x), .h_readyout_x(h_readyout_x), .h_resp_x(h_resp_x),
    .h_rdata(rdata_b), .h_ready(ready_b), .h_resp(resp_b), .h_err_cnt(cnt_b)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        ready;
    logic        resp;
    logic [7:0]  cnt;
    logic [1:0]  cnt_b;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  logic [NS-1:0] m_dsel;
  int            m_state;
  int            m_cnt;
  int            m_cnt_b;

  logic          pin;
  logic [31:0]   pin_val [NS];

  logic          d_en;
  logic [31:0]   d_rdata;
  logic          d_ready;
  logic          d_resp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    bit   found;
    e.rdata = 32'h0;
    e.ready = 1'b1;
    e.resp  = 1'b0;
    e.cnt   = 8'(m_cnt);
    e.cnt_b = 2'(m_cnt_b);
    found   = 1'b0;
    if (m_dsel == 5'b00000) begin
      e.ready = (m_state != 1);
      e.resp  = (m_state != 0);
    end else begin
      for (int i = 0; i < NS; i++) begin
        if (m_dsel[i] && !found) begin
          found   = 1'b1;
          e.rdata = h_rdata_x[i*DW +: DW];
          e.ready = h_readyout_x[i];
          e.resp  = h_resp_x[i];
        end
      end
    end
    return e;
  endfunction

  task automatic model_reset();
    m_dsel  = 5'b00000;
    m_state = 0;
    m_cnt   = 0;
    m_cnt_b = 0;
  endtask

  task automatic expect_next(input logic [31:0] rd, input logic rdy, input logic rsp);
    d_en    = 1'b1;
    d_rdata = rd;
    d_ready = rdy;
    d_resp  = rsp;
  endtask

  // One bus cycle: drive, predict, compare at negedge, advance the model at posedge.
  task automatic cyc(input string tag, input logic [NS-1:0] sel, input logic [1:0] trans,
                     input logic [NS-1:0] rdy, input logic [NS-1:0] rsp);
    exp_t e;
    bit   unm;
    h_sel_x      = sel;
    h_trans      = trans;
    h_readyout_x = rdy;
    h_resp_x     = rsp;
    for (int i = 0; i < NS; i++) begin
      h_rdata_x[i*DW +: DW] = pin ? pin_val[i] : $urandom;
    end
    @(negedge h_clk);
    sb_q.push_back(model_out());
    e = sb_q.pop_front();
    check({tag, "_rdata"}, 64'(h_rdata), 64'(e.rdata));
    check({tag, "_ready"}, 64'(h_ready), 64'(e.ready));
    check({tag, "_resp"},  64'(h_resp),  64'(e.resp));
    check({tag, "_cnt"},   64'(h_err_cnt), 64'(e.cnt));
    check({tag, "_rdata_b"}, 64'(rdata_b), 64'(e.rdata));
    check({tag, "_ready_b"}, 64'(ready_b), 64'(e.ready));
    check({tag, "_resp_b"},  64'(resp_b),  64'(e.resp));
    check({tag, "_cnt_b"},   64'(cnt_b),   64'(e.cnt_b));
    if (d_en) begin
      check({tag, "_drd"},  64'(h_rdata), 64'(d_rdata));
      check({tag, "_drdy"}, 64'(h_ready), 64'(d_ready));
      check({tag, "_drsp"}, 64'(h_resp),  64'(d_resp));
      d_en = 1'b0;
    end
    @(posedge h_clk);
    unm = (sel == 5'b00000) && trans[1];
    case (m_state)
      0: m_state = (e.ready && unm) ? 1 : 0;
      1: m_state = 2;
      2: begin
        if (m_cnt < 255) m_cnt++;
        if (m_cnt_b < 3) m_cnt_b++;
        m_state = unm ? 1 : 0;
      end
      default: m_state = 0;
    endcase
    if (e.ready) m_dsel = sel;
    #1;
  endtask

  initial begin
    pin_val[0] = 32'h0BAD0000;
    pin_val[1] = 32'h11111111;
    pin_val[2] = 32'hDEADBEEF;
    pin_val[3] = 32'h33333333;
    pin_val[4] = 32'h44444444;
    pin          = 1'b0;
    d_en         = 1'b0;
    d_rdata      = 32'h0;
    d_ready      = 1'b0;
    d_resp       = 1'b0;
    h_rst        = 1'b1;
    h_sel_x      = 5'b00000;
    h_trans      = 2'b00;
    h_rdata_x    = '1;
    h_readyout_x = 5'b11111;
    h_resp_x     = 5'b11111;
    model_reset();
    #2;
    check("rst_ready", 64'(h_ready), 64'd1);
    check("rst_resp",  64'(h_resp),  64'd0);
    check("rst_rdata", 64'(h_rdata), 64'd0);
    check("rst_cnt",   64'(h_err_cnt), 64'd0);
    @(negedge h_clk);
    h_rst = 1'b0;
    @(posedge h_clk);
    #1;

    // Reset asserted mid-ERR1 without a clock edge
    cyc("t1_unm", 5'b00000, 2'b10, 5'b11111, 5'b00000);
    cyc("t1_e1",  5'b00000, 2'b00, 5'b11111, 5'b00000);
    cyc("t1_e2",  5'b00000, 2'b00, 5'b11111, 5'b00000);
    cyc("t1_ok",  5'b00000, 2'b00, 5'b11111, 5'b00000);
    check("t1_cnt_before", 64'(h_err_cnt), 64'd1);
    cyc("t1_unm2", 5'b00000, 2'b10, 5'b11111, 5'b00000);
    check("t1_in_err1", 64'(h_ready), 64'd0);
    h_rst = 1'b1;
    #1;
    check("t1_rst_ready", 64'(h_ready), 64'd1);
    check("t1_rst_resp",  64'(h_resp),  64'd0);
    check("t1_rst_rdata", 64'(h_rdata), 64'd0);
    check("t1_rst_cnt",   64'(h_err_cnt), 64'd0);
    model_reset();
    h_rst = 1'b0;
    #1;
    cyc("t1_post", 5'b00000, 2'b00, 5'b11111, 5'b00000);

    // Mapped read from slave 2
    pin = 1'b1;
    cyc("t2_addr", 5'b00100, 2'b10, 5'b11111, 5'b00000);
    expect_next(32'hDEADBEEF, 1'b1, 1'b0);
    cyc("t2_data", 5'b00000, 2'b00, 5'b11111, 5'b00000);

    // Wait states on slave 1 while the next address targets slave 3
    cyc("t3_addr", 5'b00010, 2'b10, 5'b11111, 5'b00000);
    for (int k = 0; k < 3; k++) begin
      expect_next(32'h11111111, 1'b0, 1'b0);
      cyc("t3_wait", 5'b01000, 2'b10, 5'b11101, 5'b00000);
    end
    expect_next(32'h11111111, 1'b1, 1'b0);
    cyc("t3_rel", 5'b01000, 2'b10, 5'b11111, 5'b00000);
    expect_next(32'h33333333, 1'b1, 1'b0);
    cyc("t3_s3", 5'b00000, 2'b00, 5'b11111, 5'b00000);
    pin = 1'b0;

    // Single unmapped NONSEQ
    cyc("t4_a", 5'b00000, 2'b10, 5'b11111, 5'b00000);
    expect_next(32'h0, 1'b0, 1'b1);
    cyc("t4_e1", 5'b00000, 2'b00, 5'b11111, 5'b00000);
    expect_next(32'h0, 1'b1, 1'b1);
    cyc("t4_e2", 5'b00000, 2'b00, 5'b11111, 5'b00000);
    expect_next(32'h0, 1'b1, 1'b0);
    cyc("t4_ok", 5'b00000, 2'b00, 5'b11111, 5'b00000);
    check("t4_cnt", 64'(h_err_cnt), 64'd1);

    // Back-to-back unmapped SEQ x3 then IDLE
    cyc("t5_a", 5'b00000, 2'b11, 5'b11111, 5'b00000);
    for (int k = 0; k < 3; k++) begin
      expect_next(32'h0, 1'b0, 1'b1);
      cyc("t5_e1", 5'b00000, (k < 2) ? 2'b11 : 2'b00, 5'b11111, 5'b00000);
      expect_next(32'h0, 1'b1, 1'b1);
      cyc("t5_e2", 5'b00000, (k < 2) ? 2'b11 : 2'b00, 5'b11111, 5'b00000);
    end
    expect_next(32'h0, 1'b1, 1'b0);
    cyc("t5_idle", 5'b00000, 2'b00, 5'b11111, 5'b00000);
    check("t5_cnt", 64'(h_err_cnt), 64'd4);
    cyc("t5_busy", 5'b00000, 2'b01, 5'b11111, 5'b00000);
    expect_next(32'h0, 1'b1, 1'b0);
    cyc("t5_okay", 5'b00000, 2'b00, 5'b11111, 5'b00000);
    check("t5_cnt_idle", 64'(h_err_cnt), 64'd4);

    // Saturation of the 2-bit counter, then multi-hot select
    for (int k = 0; k < 5; k++) begin
      cyc("t6_a",  5'b00000, 2'b10, 5'b11111, 5'b00000);
      cyc("t6_e1", 5'b00000, 2'b00, 5'b11111, 5'b00000);
      cyc("t6_e2", 5'b00000, 2'b00, 5'b11111, 5'b00000);
    end
    cyc("t6_idle", 5'b00000, 2'b00, 5'b11111, 5'b00000);
    check("t6_sat", 64'(cnt_b), 64'd3);
    check("t6_cnt", 64'(h_err_cnt), 64'd9);
    pin = 1'b1;
    cyc("t6_mh", 5'b10100, 2'b10, 5'b11111, 5'b00000);
    expect_next(32'hDEADBEEF, 1'b0, 1'b1);
    cyc("t6_mhd", 5'b00000, 2'b00, 5'b11011, 5'b00100);
    expect_next(32'hDEADBEEF, 1'b1, 1'b0);
    cyc("t6_mhr", 5'b00000, 2'b00, 5'b11111, 5'b00000);
    pin = 1'b0;

    // Random traffic against the model
    for (int k = 0; k < 60; k++) begin
      logic [NS-1:0] s;
      case ($urandom_range(0, 3))
        0: s = 5'b00000;
        1: s = 5'(1 << $urandom_range(0, NS - 1));
        default: s = 5'($urandom);
      endcase
      cyc("rnd", s, 2'($urandom), 5'($urandom) | 5'b00001, 5'($urandom));
    end
    cyc("rnd_end", 5'b00000, 2'b00, 5'b11111, 5'b00000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
